// File: rtl/gray_counter_ctl.sv
// Gray-code counter with enable, up/down, synchronous load and a programmable terminal count.
// The binary and Gray values are registered together, so gray_o never lags bin_o.
module gray_counter_ctl #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter bit               LOAD_GRAY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             zero_o,
  output logic             wrap_o,
  output logic             load_err_o
);

  logic [WIDTH-1:0] bin_q, gray_q;
  logic             wrap_q, err_q;
  logic [WIDTH-1:0] ld_g2b, ld_v;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt, err_nxt;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    ld_g2b = '0;
    for (int i = 0; i < WIDTH; i++) ld_g2b[i] = ^(load_val >> i);
  end

  assign ld_v = LOAD_GRAY ? ld_g2b : load_val;

  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      if (ld_v > MAX_VAL) begin
        bin_nxt = MAX_VAL;
        err_nxt = 1'b1;
      end else begin
        bin_nxt = ld_v;
      end
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_VAL) begin
          bin_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          bin_nxt = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          bin_nxt  = MAX_VAL;
          wrap_nxt = 1'b1;
        end else begin
          bin_nxt = bin_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= bin_nxt ^ (bin_nxt >> 1);
      wrap_q <= wrap_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bin_o      = bin_q;
  assign gray_o     = gray_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = err_q;
  assign zero_o     = (bin_q == '0) & ~rst;

endmodule
